// File: rtl/var_delay_line.sv
// Runtime-programmable multi-lane delay line: CHANNELS lanes delayed by 1..MAX_DEPTH
// enabled cycles, with per-sample valid, stall, flush and a structural fill indicator.

module var_delay_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_DEPTH  = 16,
    parameter int DEPTH_W    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DEPTH_W-1:0]    tap,
    output logic [DATA_WIDTH-1:0] dout
);
    // Stage i holds the sample that entered i enabled shifts ago.
    logic [MAX_DEPTH:1][DATA_WIDTH-1:0] stg;

    always_ff @(posedge clk) begin
        if (rst)        stg <= '0;
        else if (shift) stg <= {stg[MAX_DEPTH-1:1], din};
    end

    always_comb begin
        dout = '0;
        for (int i = 1; i <= MAX_DEPTH; i++)
            if (tap == DEPTH_W'(i)) dout = stg[i];
    end
endmodule

module var_delay_line #(
    parameter  int DATA_WIDTH = 8,
    parameter  int CHANNELS   = 4,
    parameter  int MAX_DEPTH  = 16,
    localparam int DEPTH_W    = $clog2(MAX_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [CHANNELS*DATA_WIDTH-1:0] din,
    input  logic                           din_valid,
    input  logic                           cfg_load,
    input  logic [DEPTH_W-1:0]             cfg_delay,
    input  logic                           flush,
    output logic [CHANNELS*DATA_WIDTH-1:0] dout,
    output logic                           dout_valid,
    output logic [DEPTH_W-1:0]             delay_cur,
    output logic                           primed
);
    typedef struct packed {
        logic               load;
        logic               flush;
        logic [DEPTH_W-1:0] delay;
    } cfg_req_t;

    cfg_req_t                               cfg;
    logic                                   clr, shift;
    logic [DEPTH_W-1:0]                     dly_clamped, fill;
    logic [MAX_DEPTH:1]                     vld_pipe;
    logic [CHANNELS-1:0][DATA_WIDTH-1:0]    din_l, dout_l;

    assign cfg   = '{load: cfg_load, flush: flush, delay: cfg_delay};
    assign clr   = cfg.load | cfg.flush;
    // A load/flush cycle swallows din even when en=1.
    assign shift = en & ~clr;
    assign din_l = din;
    assign dout  = dout_l;

    always_comb begin
        dly_clamped = cfg.delay;
        if (cfg.delay == '0)                        dly_clamped = DEPTH_W'(1);
        else if (cfg.delay > DEPTH_W'(MAX_DEPTH))   dly_clamped = DEPTH_W'(MAX_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            delay_cur <= DEPTH_W'(MAX_DEPTH);
            fill      <= '0;
        end else if (clr) begin
            vld_pipe <= '0;
            fill     <= '0;
            if (cfg.load) delay_cur <= dly_clamped;
        end else if (shift) begin
            vld_pipe <= {vld_pipe[MAX_DEPTH-1:1], din_valid};
            if (fill != delay_cur) fill <= fill + DEPTH_W'(1);
        end
    end

    always_comb begin
        dout_valid = 1'b0;
        for (int i = 1; i <= MAX_DEPTH; i++)
            if (delay_cur == DEPTH_W'(i)) dout_valid = vld_pipe[i];
    end

    assign primed = (fill == delay_cur);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        var_delay_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .MAX_DEPTH  (MAX_DEPTH),
            .DEPTH_W    (DEPTH_W)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .shift (shift),
            .din   (din_l[k]),
            .tap   (delay_cur),
            .dout  (dout_l[k])
        );
    end
endmodule

// File: tb/tb_var_delay_line.sv
// Directed bench for var_delay_line: scoreboard of in-flight valid samples keyed by
// the enabled-shift count at which each must reach dout.

module tb_var_delay_line;
    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          rst, en, din_valid, cfg_load, flush;
    logic [31:0]   din;
    logic [DW-1:0] cfg_delay;
    logic [31:0]   dout;
    logic          dout_valid, primed;
    logic [DW-1:0] delay_cur;

    var_delay_line dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .din_valid  (din_valid),
        .cfg_load   (cfg_load),
        .cfg_delay  (cfg_delay),
        .flush      (flush),
        .dout       (dout),
        .dout_valid (dout_valid),
        .delay_cur  (delay_cur),
        .primed     (primed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        int          due;
    } sb_t;

    sb_t         q[$];
    int          n_chk = 0, n_err = 0;
    int          shifts = 0, m_dly = 16, m_fill = 0;
    logic        exp_v = 1'b0;
    logic [31:0] exp_d = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model at the edge, check at the following negedge.
    task automatic step(input logic r, input logic e, input logic dv, input logic [31:0] d,
                        input logic cl, input logic [DW-1:0] cd, input logic fl);
        rst = r; en = e; din_valid = dv; din = d; cfg_load = cl; cfg_delay = cd; flush = fl;
        @(posedge clk);
        if (r) begin
            m_dly = 16; m_fill = 0; q.delete(); exp_v = 1'b0;
        end else if (cl || fl) begin
            if (cl) m_dly = (cd == 0) ? 1 : (cd > 16) ? 16 : int'(cd);
            m_fill = 0; q.delete(); exp_v = 1'b0;
        end else if (e) begin
            shifts++;
            if (dv) q.push_back('{d: d, due: shifts - 1 + m_dly});
            if (m_fill < m_dly) m_fill++;
            exp_v = 1'b0;
            if (q.size() > 0 && q[0].due == shifts) begin
                exp_v = 1'b1; exp_d = q[0].d; void'(q.pop_front());
            end
        end
        @(negedge clk);
        chk("delay_cur", 32'(delay_cur), 32'(m_dly));
        chk("primed", 32'(primed), 32'(m_fill == m_dly));
        chk("dout_valid", 32'(dout_valid), 32'(exp_v));
        if (exp_v) chk("dout", dout, exp_d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 32'h0, 0, '0, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; din_valid = 1'b0; din = '0;
        cfg_load = 1'b0; cfg_delay = '0; flush = 1'b0;
        @(negedge clk);

        // reset for two cycles
        step(1, 0, 0, 32'h0, 0, '0, 0);
        step(1, 0, 0, 32'h0, 0, '0, 0);
        chk("rst_dout", dout, 32'h0);

        // default delay 16, ch0 ramp 0x01..0x20
        for (int v = 1; v <= 32; v++) step(0, 1, 1, 32'(v), 0, '0, 0);

        // delay 3; load-cycle din is discarded
        step(0, 1, 1, 32'hDEADBEEF, 1, 5'd3, 0);
        step(0, 1, 1, {4{8'hA0}}, 0, '0, 0);
        step(0, 1, 1, {4{8'hA1}}, 0, '0, 0);
        step(0, 1, 1, {4{8'hA2}}, 0, '0, 0);
        idle(3);

        // clamping: 0 -> 1, 20 -> 16
        step(0, 1, 0, 32'h0, 1, 5'd0, 0);
        step(0, 1, 1, 32'h77777777, 0, '0, 0);
        step(0, 1, 1, 32'h12345678, 0, '0, 0);
        idle(2);
        step(0, 1, 0, 32'h0, 1, 5'd20, 0);
        idle(2);

        // stall mid-flight with delay 4
        step(0, 1, 0, 32'h0, 1, 5'd4, 0);
        step(0, 1, 1, {4{8'h55}}, 0, '0, 0);
        idle(1);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 32'hFFFFFFFF, 0, '0, 0);
        idle(3);

        // valid gaps at delay 5, then flush mid-flight
        step(0, 1, 0, 32'h0, 1, 5'd5, 0);
        step(0, 1, 1, {4{8'hB1}}, 0, '0, 0);
        step(0, 1, 0, {4{8'hB2}}, 0, '0, 0);
        step(0, 1, 1, {4{8'hB3}}, 0, '0, 0);
        idle(5);
        step(0, 1, 1, {4{8'hC1}}, 0, '0, 0);
        step(0, 1, 1, {4{8'hC2}}, 0, '0, 0);
        step(0, 0, 1, 32'h0, 0, '0, 1);
        idle(6);

        // reset beats load/en; then load+flush with delay 2
        step(0, 1, 0, 32'h0, 1, 5'd3, 0);
        step(0, 1, 1, {4{8'hE1}}, 0, '0, 0);
        step(0, 1, 1, {4{8'hE2}}, 0, '0, 0);
        step(1, 1, 1, {4{8'hE3}}, 1, 5'd7, 0);
        chk("rst_mid_dout", dout, 32'h0);
        step(0, 1, 0, 32'h0, 1, 5'd2, 1);
        step(0, 1, 1, {4{8'hD1}}, 0, '0, 0);
        idle(3);

        chk("sb_empty", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/var_delay_line.md
Name: var_delay_line

Overview:
- Multi-channel, runtime-programmable delay line; successor to the fixed-length single-channel shift register.
- Delays CHANNELS lanes of DATA_WIDTH bits by a configurable 1..MAX_DEPTH cycles.
- Carries a per-sample valid bit and supports stall and flush.
- Sits in datapath alignment paths where latency must be matched at run time.

Parameters:
- DATA_WIDTH, 8, bits per channel
- CHANNELS, 4, number of parallel lanes sharing one delay setting
- MAX_DEPTH, 16, maximum delay in enabled cycles (>=2)
- DEPTH_W, $clog2(MAX_DEPTH+1), width of delay/count fields (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  shift enable; 0 = stall, all state held
- din  in  CHANNELS*DATA_WIDTH  input samples; channel k at [k*DATA_WIDTH +: DATA_WIDTH]
- din_valid  in  1  qualifies din
- cfg_load  in  1  one-cycle pulse: latch cfg_delay and flush
- cfg_delay  in  DEPTH_W  requested delay
- flush  in  1  clear all in-flight valid bits
- dout  out  CHANNELS*DATA_WIDTH  delayed samples, same lane packing as din
- dout_valid  out  1  qualifies dout
- delay_cur  out  DEPTH_W  active delay setting
- primed  out  1  line holds delay_cur enabled shifts since last flush/load

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset, rst=1 at a rising edge:
  - all data stages <= 0; all valid bits <= 0
  - delay_cur <= MAX_DEPTH; fill counter <= 0
  - dout = 0, dout_valid = 0, primed = 0 from the next cycle
  - reset overrides en, cfg_load and flush
- Storage: MAX_DEPTH stages, each holding CHANNELS*DATA_WIDTH data bits plus 1 valid bit.
- Shift, en=1 and no cfg_load/flush:
  - stage0 <= {din_valid, din}; stage[i] <= stage[i-1]
  - data shifts regardless of din_valid
- Stall, en=0: nothing changes, including the fill counter. Outputs hold.
- Output tap:
  - dout/dout_valid = stage[delay_cur-1], through a mux from registers with no extra register.
  - A sample presented with en=1 at edge t appears at dout after exactly delay_cur enabled edges.
- cfg_load=1 at an edge:
  - delay_cur <= clamp(cfg_delay): 0 becomes 1; values above MAX_DEPTH become MAX_DEPTH
  - all valid bits <= 0; fill counter <= 0
  - data bits are not cleared
  - the din presented that cycle is discarded, even if en=1
- flush=1 (without cfg_load): same as cfg_load except delay_cur is unchanged.
- cfg_load and flush together: treated as cfg_load.
- Fill counter:
  - increments on each enabled shift, saturating at delay_cur
  - primed = (fill counter == delay_cur)
  - valid bits already guarantee dout_valid=0 for stale data; primed reports structural fill only.
- Simultaneous en=0 with cfg_load or flush: the load/flush still takes effect.
- Valid bits never leak across a delay change. After a load to delay D, the first possible dout_valid=1 is D enabled edges after the load edge.
- Arithmetic: fill counter and delay_cur are DEPTH_W bits unsigned; the clamp comparison is unsigned.

Test Plan:
- Reset then default delay: rst 2 cycles; drive ch0=0x01..0x20 with din_valid=1, en=1 -> ch0 out 0x01 with dout_valid=1 exactly 16 edges after first sample; primed=1 at the same cycle.
- Program delay: cfg_load with cfg_delay=3, then stream 0xA0,0xA1,0xA2 on all 4 channels -> dout_valid low for 3 edges, then 0xA0,0xA1,0xA2 on consecutive cycles; delay_cur=3.
- Clamping: cfg_delay=0 -> delay_cur=1 and one-cycle latency; cfg_delay=20 -> delay_cur=16.
- Stall: delay=4, sample 0x55 injected, en=0 for 5 cycles mid-flight -> 0x55 emerges after 4 enabled edges (9 clocks total); dout held stable during the stall.
- Flush and valid gaps:
  - delay=5, din_valid pattern 1,0,1 -> dout_valid pattern 1,0,1 five edges later
  - flush asserted mid-flight -> no dout_valid for the in-flight samples; primed drops to 0 and re-asserts 5 enabled edges later
- Reset mid-operation and precedence:
  - rst asserted with cfg_load=1 and en=1 -> delay_cur=16, all outputs 0
  - cfg_load+flush together with cfg_delay=2 -> delay_cur=2
